regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (Rd/Data/RegWrite) between two writeback sources:
//  A = ALU/immediate path, B = load/multi-cycle unit. Each source has a 1-entry holding slot.

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two writeback sources:
// A (ALU/immediate path) and B (load/multi-cycle unit). Each source has a
// one-entry holding slot. A has fixed priority, but B takes priority once its
// full slot has waited MAX_WAIT cycles without a grant, so B cannot starve.
// Port-side outputs are registered and drive the register file directly.
// A write to R0 is consumed and dropped without touching the port outputs.
// Optional build macro: WB_ARB_STATS_EN adds conflict_cnt, a saturating count
// of the cycles in which both slots were full. Arbitration is identical
// with or without the macro.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Data,
    output logic              grant_b
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic {PRI_A, PRI_B} pri_e;

    pri_e              pri_q, pri_d;
    logic [3:0]        age_b_q, age_b_d;

    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_rd_q, a_rd_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_rd_q, b_rd_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;

    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              gb_q, gb_d;

    logic              gnt_a, gnt_b;

    // Priority state register and B age counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q   <= PRI_A;
            age_b_q <= 4'd0;
        end else begin
            pri_q   <= pri_d;
            age_b_q <= age_b_d;
        end
    end

    // Grant selection plus next priority state; age saturates at 15.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        age_b_d = 4'd0;
        pri_d   = PRI_A;
        if (a_full_q && b_full_q) begin
            if (pri_q == PRI_B) gnt_b = 1'b1;
            else                gnt_a = 1'b1;
        end else if (a_full_q) begin
            gnt_a = 1'b1;
        end else if (b_full_q) begin
            gnt_b = 1'b1;
        end
        if (b_full_q && !gnt_b) begin
            age_b_d = (age_b_q == 4'hF) ? age_b_q : age_b_q + 4'd1;
        end
        if (age_b_d >= MAX_WAIT_C) pri_d = PRI_B;
    end

    // A slot that is being drained this cycle can be refilled at the same edge.
    assign a_ready = !a_full_q || gnt_a;
    assign b_ready = !b_full_q || gnt_b;

    // Next state of both holding slots and of the write-port outputs.
    always_comb begin
        a_full_d = a_full_q;
        a_rd_d   = a_rd_q;
        a_data_d = a_data_q;
        b_full_d = b_full_q;
        b_rd_d   = b_rd_q;
        b_data_d = b_data_q;
        wr_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        gb_d     = 1'b0;

        if (a_valid && a_ready) begin
            a_full_d = 1'b1;
            a_rd_d   = a_rd;
            a_data_d = a_data;
        end else if (gnt_a) begin
            a_full_d = 1'b0;
        end

        if (b_valid && b_ready) begin
            b_full_d = 1'b1;
            b_rd_d   = b_rd;
            b_data_d = b_data;
        end else if (gnt_b) begin
            b_full_d = 1'b0;
        end

        if (gnt_a) begin
            if (a_rd_q != '0) begin
                wr_d   = 1'b1;
                rd_d   = a_rd_q;
                data_d = a_data_q;
            end
        end else if (gnt_b) begin
            gb_d = 1'b1;
            if (b_rd_q != '0) begin
                wr_d   = 1'b1;
                rd_d   = b_rd_q;
                data_d = b_data_q;
            end
        end
    end

    // Slot and write-port registers; reset discards any pending slot contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_q <= 1'b0;
            a_rd_q   <= '0;
            a_data_q <= '0;
            b_full_q <= 1'b0;
            b_rd_q   <= '0;
            b_data_q <= '0;
            wr_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            gb_q     <= 1'b0;
        end else begin
            a_full_q <= a_full_d;
            a_rd_q   <= a_rd_d;
            a_data_q <= a_data_d;
            b_full_q <= b_full_d;
            b_rd_q   <= b_rd_d;
            b_data_q <= b_data_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            gb_q     <= gb_d;
        end
    end

    assign RegWrite = wr_q;
    assign Rd       = rd_q;
    assign Data     = data_q;
    assign grant_b  = gb_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of cycles in which both slots are full.
    always_comb begin
        cnt_d = cnt_q;
        if (a_full_q && b_full_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Conflict counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: table-driven single-cycle vectors plus
// hand-written sequences for starvation, reset and the optional statistics.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Data;
    logic        grant_b;
`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .RegWrite (RegWrite),
        .Rd       (Rd),
        .Data     (Data),
        .grant_b  (grant_b)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_gb;
        logic        e_ar;
        logic        e_br;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
    endtask

    logic [37:0] obs_q[$];
    logic [37:0] exp_q[$];
    int          na;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Observed before the edge of each row; registered values reflect earlier rows.
        vec[0] = '{1'b1, 5'd1, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1};
        vec[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1};
        vec[2] = '{1'b1, 5'd2, 32'h2345, 1'b1, 5'd3, 32'h3456, 1'b1, 5'd1, 32'h1234, 1'b0, 1'b1, 1'b1};
        vec[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd1, 32'h1234, 1'b0, 1'b1, 1'b0};
        vec[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h2345, 1'b0, 1'b1, 1'b1};
        vec[5] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h3456, 1'b1, 1'b1, 1'b1};
        vec[6] = '{1'b1, 5'd0, 32'h5678, 1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'h3456, 1'b0, 1'b1, 1'b1};
        vec[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'h3456, 1'b0, 1'b1, 1'b1};
        vec[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'h3456, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("reset Rd", {27'd0, Rd}, 32'd0);
        chk("reset Data", Data, 32'd0);
        chk("reset grant_b", {31'd0, grant_b}, 32'd0);
        chk("reset a_ready", {31'd0, a_ready}, 32'd1);
        chk("reset b_ready", {31'd0, b_ready}, 32'd1);
`ifdef WB_ARB_STATS_EN
        chk("reset conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table: A only, A/B collision, R0 drop.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].av, vec[i].ard, vec[i].ad, vec[i].bv, vec[i].brd, vec[i].bd);
            #1;
            chk($sformatf("v%0d RegWrite", i), {31'd0, RegWrite}, {31'd0, vec[i].e_wr});
            chk($sformatf("v%0d Rd", i), {27'd0, Rd}, {27'd0, vec[i].e_rd});
            chk($sformatf("v%0d Data", i), Data, vec[i].e_data);
            chk($sformatf("v%0d grant_b", i), {31'd0, grant_b}, {31'd0, vec[i].e_gb});
            chk($sformatf("v%0d a_ready", i), {31'd0, a_ready}, {31'd0, vec[i].e_ar});
            chk($sformatf("v%0d b_ready", i), {31'd0, b_ready}, {31'd0, vec[i].e_br});
        end

        // Starvation: A streams every cycle while B holds one write.
        na = 0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t < 10) drive(1'b1, 5'd10 + 5'(na), 32'hA000 + 32'(na), t == 0, 5'd4, 32'h4567);
            else        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            #1;
            if (RegWrite) obs_q.push_back({grant_b, Rd, Data});
            if (t >= 1 && t <= 4) chk($sformatf("starve t%0d b_ready", t), {31'd0, b_ready}, 32'd0);
            if (t == 5) chk("starve t5 a_ready", {31'd0, a_ready}, 32'd0);
            if (t == 5) chk("starve t5 b_ready", {31'd0, b_ready}, 32'd1);
            if (t == 6) chk("starve t6 a_ready", {31'd0, a_ready}, 32'd1);
            if (a_valid && a_ready) na++;
        end
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 5'd10 + 5'(k), 32'hA000 + 32'(k)});
        exp_q.push_back({1'b1, 5'd4, 32'h4567});
        for (int k = 4; k < 9; k++) exp_q.push_back({1'b0, 5'd10 + 5'(k), 32'hA000 + 32'(k)});
        chk("starve A accepted", na, 32'd9);
        chk("starve write count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_q.size()) chk($sformatf("starve write%0d", k), 32'(obs_q[k] >> 6), 32'(exp_q[k] >> 6));
            if (k < obs_q.size()) chk($sformatf("starve data%0d", k), obs_q[k][31:0], exp_q[k][31:0]);
        end

        // Reset with both slots full: outputs clear at once, nothing stale follows.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("preload b_ready", {31'd0, b_ready}, 32'd0);
        chk("preload Rd", {27'd0, Rd}, 32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("midrst Rd", {27'd0, Rd}, 32'd0);
        chk("midrst Data", Data, 32'd0);
        chk("midrst grant_b", {31'd0, grant_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst a_ready", {31'd0, a_ready}, 32'd1);
        chk("postrst b_ready", {31'd0, b_ready}, 32'd1);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst t%0d RegWrite", t), {31'd0, RegWrite}, 32'd0);
        end

`ifdef WB_ARB_STATS_EN
        // Both slots full for three cycles.
        chk("stats start", {16'd0, conflict_cnt}, 32'd0);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            drive(t < 3, 5'd7 + 5'(t), 32'h70 + 32'(t), t == 0, 5'd8, 32'h80);
        end
        #1;
        chk("stats conflict_cnt", {16'd0, conflict_cnt}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
